// File: rtl/seq_divider_core_if.sv
// Start/result bundle for the iterative restoring divider.
// The requester owns the start strobe and operands; the divider owns status and results.
interface seq_divider_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// Results are registered and held until the next completed operation.
module seq_divider_core #(
    parameter int DATA_WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    seq_divider_core_if.slave bus
);
    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] pr, pr_n;
    logic [DATA_WIDTH-1:0] q, q_n;
    logic [DATA_WIDTH-1:0] dsr, dsr_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] quo, quo_n;
    logic [DATA_WIDTH-1:0] rem, rem_n;
    logic                  dbz, dbz_n;
    logic [DATA_WIDTH:0]   pr_sh;
    logic [DATA_WIDTH:0]   trial;

    // The stored partial remainder is always below the divisor, so only the
    // shifted value needs the extra bit.
    assign pr_sh = {pr, q[DATA_WIDTH-1]};
    assign trial = pr_sh - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pr    <= '0;
            q     <= '0;
            dsr   <= '0;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_n;
            pr    <= pr_n;
            q     <= q_n;
            dsr   <= dsr_n;
            cnt   <= cnt_n;
            quo   <= quo_n;
            rem   <= rem_n;
            dbz   <= dbz_n;
        end
    end

    always_comb begin
        state_n = state;
        pr_n    = pr;
        q_n     = q;
        dsr_n   = dsr;
        cnt_n   = cnt;
        quo_n   = quo;
        rem_n   = rem;
        dbz_n   = dbz;
        unique case (state)
            RUN: begin
                pr_n  = trial[DATA_WIDTH] ? pr_sh[DATA_WIDTH-1:0]
                                          : trial[DATA_WIDTH-1:0];
                q_n   = {q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
                cnt_n = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_n = DONE;
                    quo_n   = q_n;
                    rem_n   = pr_n;
                    dbz_n   = 1'b0;
                end
            end
            default: begin
                if (bus.start) begin
                    dsr_n = bus.divisor;
                    pr_n  = '0;
                    q_n   = bus.dividend;
                    cnt_n = '0;
                    if (bus.divisor == '0) begin
                        state_n = DONE;
                        quo_n   = '1;
                        rem_n   = bus.dividend;
                        dbz_n   = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider_core.sv
// Directed and random checks of seq_divider_core against a bench-side
// scoreboard of expected quotient/remainder/div_by_zero values.
module tb_seq_divider_core;
    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    seq_divider_core_if #(.DATA_WIDTH(8)) ifc ();

    seq_divider_core #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input bit poke, input bit tag_on);
        exp_t e;
        exp_t got_e;
        int   lat;
        int   busy_n;
        bit   got;
        e.q = (b == 0) ? 8'hFF : a / b;
        e.r = (b == 0) ? a : a % b;
        e.z = (b == 0);
        sb.push_back(e);
        @(negedge clk);
        ifc.dividend = a;
        ifc.divisor  = b;
        ifc.start    = 1'b1;
        lat    = 0;
        busy_n = 0;
        got    = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ifc.busy === 1'b1) busy_n++;
            if (ifc.done === 1'b1) got = 1'b1;
            if (poke && lat >= 3 && lat <= 5) begin
                ifc.start    = 1'b1;
                ifc.dividend = 8'd50;
                ifc.divisor  = 8'd5;
            end else begin
                ifc.start    = 1'b0;
                ifc.dividend = 8'($urandom);
                ifc.divisor  = 8'($urandom);
            end
        end
        ifc.start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
            got_e = sb.pop_front();
            chk("quotient", 32'(ifc.quotient), 32'(got_e.q));
            chk("remainder", 32'(ifc.remainder), 32'(got_e.r));
            chk("div_by_zero", 32'(ifc.div_by_zero), 32'(got_e.z));
            chk("latency", 32'(lat), (b == 0) ? 32'd1 : 32'd9);
            if (tag_on) chk("busy_cycles", 32'(busy_n),
                            (b == 0) ? 32'd0 : 32'd8);
            @(negedge clk);
            chk("done_one_cycle", 32'(ifc.done), 32'd0);
            if (tag_on) chk("result_hold", 32'(ifc.quotient), 32'(got_e.q));
        end else begin
            sb.delete();
        end
    endtask

    initial begin
        int dc0;
        logic [7:0] a;
        logic [7:0] b;
        ifc.start    = 1'b0;
        ifc.dividend = '0;
        ifc.divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_quotient", 32'(ifc.quotient), 32'd0);
        chk("rst_remainder", 32'(ifc.remainder), 32'd0);
        chk("rst_dbz", 32'(ifc.div_by_zero), 32'd0);
        rst = 1'b0;

        run_op(8'd100, 8'd7, 1'b0, 1'b1);
        run_op(8'd255, 8'd1, 1'b0, 1'b1);
        run_op(8'd0, 8'd9, 1'b0, 1'b1);
        run_op(8'd5, 8'd9, 1'b0, 1'b1);
        run_op(8'd200, 8'd200, 1'b0, 1'b1);
        run_op(8'd77, 8'd0, 1'b0, 1'b1);
        run_op(8'd10, 8'd3, 1'b0, 1'b1);

        // start pulses while busy must be ignored
        dc0 = done_cnt;
        run_op(8'd100, 8'd7, 1'b1, 1'b1);
        repeat (12) @(negedge clk);
        chk("single_done", 32'(done_cnt - dc0), 32'd1);

        // reset in the middle of a divide
        dc0 = done_cnt;
        @(negedge clk);
        ifc.dividend = 8'd100;
        ifc.divisor  = 8'd7;
        ifc.start    = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_done", 32'(ifc.done), 32'd0);
        chk("abort_quotient", 32'(ifc.quotient), 32'd0);
        chk("abort_remainder", 32'(ifc.remainder), 32'd0);
        chk("abort_dbz", 32'(ifc.div_by_zero), 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        run_op(8'd9, 8'd2, 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 13 == 0) a = 8'd0;
            if (i % 17 == 0) a = 8'hFF;
            if (i % 19 == 0) b = 8'd0;
            if (i % 23 == 0) b = 8'hFF;
            if (i % 29 == 0) b = 8'd1;
            run_op(a, b, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
